// File: rtl/core_test_sequencer.sv
// core_test_sequencer: resets the core, runs it for a fixed budget or until halt,
// then compares a list of architectural registers against expected values.
module core_test_sequencer #(
  parameter int XLEN = 32,
  parameter int NUM_CHECKS = 4,
  parameter int RESET_CYCLES = 2,
  parameter int RUN_CYCLES = 25,
  localparam int FW = $clog2(NUM_CHECKS + 1),
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int MAXC = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES,
  localparam int CW = $clog2(MAXC + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic                       core_halt_i,
  input  logic [NUM_CHECKS*5-1:0]    check_addr_i,
  input  logic [NUM_CHECKS*XLEN-1:0] check_exp_i,
  input  logic [XLEN-1:0]            dbg_rdata_i,
  output logic                       core_rst_n_o,
  output logic [4:0]                 dbg_raddr_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       timeout_o,
  output logic [FW-1:0]              fail_count_o,
  output logic [IW-1:0]              first_fail_idx_o
);
  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_CHECK, S_DONE} state_t;
  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  idx_q;
  logic           mode_q;
  logic           core_rst_n_q;
  logic [4:0]     dbg_raddr_q;
  logic           busy_q;
  logic           done_q;
  logic           pass_q;
  logic           timeout_q;
  logic [FW-1:0]  fail_count_q;
  logic [IW-1:0]  first_fail_idx_q;
  logic [XLEN-1:0] cur_exp;
  logic [4:0]     nxt_addr;
  logic           mis;
  logic           last;
  logic           expiry;
  logic [FW-1:0]  fail_count_d;
  // dbg_raddr is registered, so it is loaded one cycle ahead with the next check's address
  always_comb begin
    cur_exp = '0;
    nxt_addr = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (i == int'(idx_q)) cur_exp = check_exp_i[XLEN*i +: XLEN];
      if (i == int'(idx_q) + 1) nxt_addr = check_addr_i[5*i +: 5];
    end
  end
  assign mis = dbg_rdata_i != cur_exp;
  assign last = idx_q == IW'(NUM_CHECKS - 1);
  assign expiry = cnt_q == CW'(RUN_CYCLES - 1);
  assign fail_count_d = fail_count_q + FW'(mis);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      mode_q <= 1'b0;
      core_rst_n_q <= 1'b0;
      dbg_raddr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      timeout_q <= 1'b0;
      fail_count_q <= '0;
      first_fail_idx_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start_i) begin
          state_q <= S_RESET;
          cnt_q <= '0;
          idx_q <= '0;
          mode_q <= mode_i;
          core_rst_n_q <= 1'b0;
          busy_q <= 1'b1;
          done_q <= 1'b0;
          pass_q <= 1'b0;
          timeout_q <= 1'b0;
          fail_count_q <= '0;
          first_fail_idx_q <= '0;
        end
        S_RESET: if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          state_q <= S_RUN;
          cnt_q <= '0;
          core_rst_n_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          // halt is tested first so it wins over a coincident timeout
          if (mode_q ? core_halt_i : expiry) begin
            state_q <= S_CHECK;
            idx_q <= '0;
            dbg_raddr_q <= check_addr_i[4:0];
          end else if (expiry) begin
            state_q <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        S_CHECK: begin
          idx_q <= idx_q + 1'b1;
          dbg_raddr_q <= nxt_addr;
          fail_count_q <= fail_count_d;
          if (mis && fail_count_q == '0) first_fail_idx_q <= idx_q;
          if (last) begin
            state_q <= S_DONE;
            dbg_raddr_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= fail_count_d == '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign core_rst_n_o = core_rst_n_q;
  assign dbg_raddr_o = dbg_raddr_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
  assign timeout_o = timeout_q;
  assign fail_count_o = fail_count_q;
  assign first_fail_idx_o = first_fail_idx_q;
endmodule

// File: tb/tb_core_test_sequencer.sv
// tb_core_test_sequencer: table-driven and randomized checks of the test sequencer
// against a stub register file and a cycle-count reference model.
module tb_core_test_sequencer;
  localparam int XLEN = 32;
  localparam int N = 4;
  localparam int R = 2;
  localparam int RC = 25;
  localparam int FW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic halt = 1'b0;
  logic [N*5-1:0] caddr = '0;
  logic [N*XLEN-1:0] cexp = '0;
  logic core_rst_n;
  logic [4:0] raddr;
  logic [XLEN-1:0] rdata;
  logic busy, done, pass, tmo;
  logic [FW-1:0] fc;
  logic [IW-1:0] ffi;
  logic [XLEN-1:0] regs [32];
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic m;
    int hs, bs, x2, x5, lat, f, ff, p, to;
  } vec_t;
  vec_t vecs [8];
  core_test_sequencer #(.XLEN(XLEN), .NUM_CHECKS(N), .RESET_CYCLES(R), .RUN_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .core_halt_i(halt),
    .check_addr_i(caddr), .check_exp_i(cexp), .dbg_rdata_i(rdata),
    .core_rst_n_o(core_rst_n), .dbg_raddr_o(raddr), .busy_o(busy), .done_o(done),
    .pass_o(pass), .timeout_o(tmo), .fail_count_o(fc), .first_fail_idx_o(ffi)
  );
  assign rdata = regs[raddr];
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask
  // hs: edge offset (from the start edge) at which halt is first sampled high; bs: sample index at which start is re-pulsed
  task automatic run_seq(input logic m, input int hs, input int bs, input int lat,
                         input int f, input int ff, input int p, input int to);
    int n, lows, got, cs;
    bit ra_ok, ex_ok, clr_ok;
    logic [4:0] exp_ra;
    @(negedge clk);
    mode = m;
    halt = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~m;
    n = 0; lows = 0; got = -1; ra_ok = 1; ex_ok = 1;
    clr_ok = (fc == 0) && !done && busy && !pass && !tmo;
    cs = to ? 32'h4000_0000 : lat - N;
    while (n <= 200) begin
      if (!core_rst_n) lows++;
      exp_ra = (n >= cs && n < cs + N) ? caddr[5*(n-cs) +: 5] : 5'd0;
      if (raddr !== exp_ra) ra_ok = 0;
      if ((busy && done) || (pass && !done)) ex_ok = 0;
      if (done) begin
        got = n;
        break;
      end
      if (n == hs - 1) halt = 1'b1;
      if (n == bs) start = 1'b1;
      else if (n == bs + 1) start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("start_clear", 32'(clr_ok), 1);
    chk("rst_low_cycles", lows, R);
    chk("done_latency", got, lat);
    chk("dbg_raddr_trace", 32'(ra_ok), 1);
    chk("busy_done_pass_excl", 32'(ex_ok), 1);
    chk("fail_count", 32'(fc), f);
    if (f != 0) chk("first_fail_idx", 32'(ffi), ff);
    chk("pass", 32'(pass), p);
    chk("timeout", 32'(tmo), to);
    @(posedge clk);
    #1;
    chk("done_hold", {done, core_rst_n, busy}, 3'b110);
    halt = 1'b0;
  endtask
  task automatic set_stub(input int x2, input int x5);
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 10;
    regs[2] = x2;
    regs[4] = 0;
    regs[5] = x5;
    caddr = {5'd5, 5'd4, 5'd2, 5'd1};
    cexp = {32'd100, 32'd0, 32'd10, 32'd10};
  endtask
  initial begin
    // m, hs, bs, x2, x5, lat, f, ff, p, to
    vecs[0] = '{1'b0, -1, -1, 10, 100, R+RC+N, 0, 0, 1, 0};
    vecs[1] = '{1'b0, -1, -1, 11, 99, R+RC+N, 2, 1, 0, 0};
    vecs[2] = '{1'b0, -1, -1, 10, 100, R+RC+N, 0, 0, 1, 0};
    vecs[3] = '{1'b1, R+7, -1, 10, 100, R+7+N, 0, 0, 1, 0};
    vecs[4] = '{1'b1, -1, -1, 10, 100, R+RC, 0, 0, 0, 1};
    vecs[5] = '{1'b1, R+RC, -1, 10, 100, R+RC+N, 0, 0, 1, 0};
    vecs[6] = '{1'b1, R+RC+1, -1, 10, 100, R+RC, 0, 0, 0, 1};
    vecs[7] = '{1'b0, -1, 10, 11, 100, R+RC+N, 1, 1, 0, 0};
    set_stub(10, 100);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_values", {core_rst_n, busy, done, pass, tmo, fc, ffi, raddr}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start", {core_rst_n, busy, done}, 0);
    for (int v = 0; v < 8; v++) begin
      set_stub(vecs[v].x2, vecs[v].x5);
      run_seq(vecs[v].m, vecs[v].hs, vecs[v].bs, vecs[v].lat, vecs[v].f, vecs[v].ff, vecs[v].p, vecs[v].to);
    end
    set_stub(10, 99);
    run_seq(1'b1, R+7, -1, R+7+N, 1, 3, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_from_done", {core_rst_n, busy, done, pass, tmo, fc, ffi, raddr}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("mid_run_state", {busy, core_rst_n}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("async_abort_mid_run", {core_rst_n, busy, done, pass, tmo, fc, ffi, raddr}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("idle_after_abort", {busy, done, core_rst_n}, 0);
    for (int t = 0; t < 24; t++) begin
      logic m;
      int hs, eff, lat, f, ff, to;
      for (int i = 0; i < 32; i++) regs[i] = $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        caddr[5*i +: 5] = 5'($urandom_range(0, 31));
        cexp[XLEN*i +: XLEN] = $urandom_range(0, 1) ? regs[caddr[5*i +: 5]] : XLEN'($urandom_range(0, 3));
      end
      m = 1'($urandom_range(0, 1));
      hs = $urandom_range(1, R + RC + 4);
      eff = (hs < R + 1) ? R + 1 : hs;
      if (!m) begin
        lat = R + RC + N; to = 0;
      end else if (eff <= R + RC) begin
        lat = eff + N; to = 0;
      end else begin
        lat = R + RC; to = 1;
      end
      f = 0; ff = 0;
      if (!to) begin
        for (int i = 0; i < N; i++) begin
          if (regs[caddr[5*i +: 5]] != cexp[XLEN*i +: XLEN]) begin
            if (f == 0) ff = i;
            f++;
          end
        end
      end
      run_seq(m, hs, -1, lat, f, ff, (!to && f == 0) ? 1 : 0, to);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/core_test_sequencer.md
# core_test_sequencer

Parametrised, synthesizable test sequencer for the RISC-V core. Generates the core's reset, runs the core either for a fixed cycle budget or until it signals halt with a timeout, then reads back up to NUM_CHECKS architectural registers through a debug read port and compares each against an expected value. It reports done, pass, timeout, a fail count and the first failing index. It sits beside `riscv_core` in simulation and FPGA bring-up tops and replaces hand-written reset/run/verify sequences.

## Interface
- XLEN, 32, register data width.
- NUM_CHECKS, 4, number of register checks; legal range 1..32.
- RESET_CYCLES, 2, cycles core_rst_n is held low after start; must be ≥1.
- RUN_CYCLES, 25, fixed run length (mode 0) or halt timeout (mode 1); must be ≥1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sequence; sampled only in IDLE or DONE.
- mode  in  1  0 = fixed run of RUN_CYCLES; 1 = run until core_halt, timeout after RUN_CYCLES; latched at start.
- core_halt  in  1  core finished; used in mode 1 only.
- check_addr  in  NUM_CHECKS*5  register index per check; entry i in bits [5i+4:5i]; must be stable while busy.
- check_exp  in  NUM_CHECKS*XLEN  expected value per check; entry i in bits [XLEN*i+XLEN-1:XLEN*i]; must be stable while busy.
- core_rst_n  out  1  reset to the core, active-low.
- dbg_raddr  out  5  register-file debug read address.
- dbg_rdata  in  XLEN  combinational read data for dbg_raddr, valid in the same cycle.
- busy  out  1  sequence in progress (RESET, RUN or CHECK).
- done  out  1  results valid; held until the next start.
- pass  out  1  done with no timeout and fail_count == 0.
- timeout  out  1  mode 1 expired without halt.
- fail_count  out  $clog2(NUM_CHECKS+1)  number of mismatches.
- first_fail_idx  out  max(1,$clog2(NUM_CHECKS))  lowest failing check index; meaningful only when fail_count != 0.

## Operation
- FSM states: IDLE, RESET, RUN, CHECK, DONE.
- IDLE: core_rst_n=0. When start=1, go to RESET, clear all result registers and latch mode.
- RESET: core_rst_n=0 for exactly RESET_CYCLES cycles, then go to RUN.
- RUN: core_rst_n=1 and a cycle counter runs.
  - Mode 0: after RUN_CYCLES cycles, go to CHECK.
  - Mode 1: core_halt=1 sampled at an edge moves to CHECK.
  - Mode 1: if RUN_CYCLES cycles elapse without halt, go to DONE with timeout=1 and perform no checks.
  - Mode 1: if halt arrives on the expiry cycle, halt wins.
- CHECK: index i runs 0..NUM_CHECKS-1, one per cycle, with dbg_raddr = check_addr[i].
  - At each edge, if dbg_rdata != check_exp[i], increment fail_count.
  - On the first mismatch, record first_fail_idx = i.
  - Index 0 is compared like any other index; no special case for x0.
  - After the last index, go to DONE.
- DONE: done=1, core_rst_n stays 1. start=1 restarts at RESET and clears results in the same edge.
- start is ignored while busy. mode is ignored except at start.
- dbg_raddr = 0 outside CHECK.
- Comparisons use full XLEN width with exact equality.

## Timing
- Reset values: state IDLE; core_rst_n=0 (asynchronously, immediately on rst_n low); dbg_raddr=0; busy=0, done=0, pass=0, timeout=0; fail_count=0; first_fail_idx=0.
- Reset mid-operation aborts to IDLE with all outputs at reset values.
- All outputs are registered or decoded from registered state only, except none; there is no combinational path from inputs to outputs.
- Start sampled at edge k gives:
  - RESET during cycles k+1 .. k+RESET_CYCLES;
  - core_rst_n rises after edge k+RESET_CYCLES;
  - in mode 0, CHECK begins after edge k+RESET_CYCLES+RUN_CYCLES;
  - done=1 after edge k+RESET_CYCLES+RUN_CYCLES+NUM_CHECKS.
- Mode 1: halt sampled at edge h gives done at h+NUM_CHECKS.
- Mode 1: timeout gives done=1 and timeout=1 after edge k+RESET_CYCLES+RUN_CYCLES.
- pass is asserted in the same cycle done rises, never earlier.
- busy and done are mutually exclusive.

## Test plan
- Mode 0, defaults, with a stub core whose file holds x1=10, x2=10, x4=0, x5=100; checks (1,10), (2,10), (4,0), (5,100) → core_rst_n low for exactly 2 cycles; done exactly 2+25+4 cycles after the start edge; pass=1; fail_count=0.
- Same stimulus with x5=99 and x2=11 → fail_count=2, first_fail_idx=1, pass=0.
- Mode 1 with halt asserted 7 cycles into RUN → done 4 cycles after the halt edge; timeout=0; pass=1.
- Mode 1 with halt never asserted → done=1 and timeout=1 after 2+25 cycles; pass=0; dbg_raddr stays 0 throughout.
- Mode 1 with halt on the 25th RUN cycle → checks run, timeout=0.
- rst_n pulsed low mid-RUN, and start pulsed while busy → immediate return to reset values; the busy-time start has no effect; a restart from DONE clears fail_count before rerunning.
